// File: rtl/axi_reg_mailbox.sv
// axi_reg_mailbox
//   Register-file target for the AXI register bridge. The CPU pushes words into a TX FIFO and
//   pops words from an RX FIFO through registers. Each FIFO connects to the fabric through a
//   valid/ready word stream.
//
//   Register map (index): 0 ID (RO), 1 STATUS (RO), 2 TXDATA (WO), 3 RXDATA (RO, pops),
//   4 CTRL (WO, self-clearing flush), 5 ERR (RW1C sticky). Any other index reads 0.
//
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   i_rreg, i_rd         read index and read strobe; o_rdata is combinational
//   o_rdata              read data for i_rreg, based on the current state
//   i_wreg, i_wdata,
//   i_wr                 write index, data and strobe
//   tx_data, tx_valid,
//   tx_ready             TX stream: head word out, consumed on valid&ready
//   rx_data, rx_valid,
//   rx_ready             RX stream: word in, accepted on valid&ready
module axi_reg_mailbox #(
    parameter int unsigned R_ADDR_WIDTH = 3,
    parameter int unsigned DEPTH_BITS   = 4,
    parameter logic [31:0] ID_VALUE     = 32'h4D424F58
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [R_ADDR_WIDTH-1:0] i_rreg,
    input  logic                    i_rd,
    output logic [31:0]             o_rdata,
    input  logic [R_ADDR_WIDTH-1:0] i_wreg,
    input  logic [31:0]             i_wdata,
    input  logic                    i_wr,
    output logic [31:0]             tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [31:0]             rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready
);

    localparam int unsigned         DEPTH    = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_LVL = (DEPTH_BITS+1)'(DEPTH);

    typedef enum logic [R_ADDR_WIDTH-1:0] {
        REG_ID     = R_ADDR_WIDTH'(0),
        REG_STATUS = R_ADDR_WIDTH'(1),
        REG_TXDATA = R_ADDR_WIDTH'(2),
        REG_RXDATA = R_ADDR_WIDTH'(3),
        REG_CTRL   = R_ADDR_WIDTH'(4),
        REG_ERR    = R_ADDR_WIDTH'(5)
    } reg_idx_e;

    logic [31:0]           tx_mem [DEPTH];
    logic [31:0]           rx_mem [DEPTH];
    logic [DEPTH_BITS-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [DEPTH_BITS:0]   tx_level, rx_level;
    logic [1:0]            err;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic wr_txdata, tx_push, tx_pop, tx_ovf, tx_flush;
    logic rd_rxdata, rx_push, rx_pop, rx_unf, rx_flush;
    logic [1:0] err_clr;
    logic [31:0] status;

    always_comb begin
        tx_full   = (tx_level == FULL_LVL);
        tx_empty  = (tx_level == '0);
        rx_full   = (rx_level == FULL_LVL);
        rx_empty  = (rx_level == '0);

        tx_valid  = !tx_empty;
        tx_data   = tx_mem[tx_rd_ptr];
        rx_ready  = !rx_full;

        // Overflow is judged on the pre-edge level, so a same-edge stream pop does not
        // make room for the incoming word.
        wr_txdata = i_wr && (i_wreg == REG_TXDATA);
        tx_push   = wr_txdata && !tx_full;
        tx_ovf    = wr_txdata && tx_full;
        tx_pop    = tx_valid && tx_ready;
        tx_flush  = i_wr && (i_wreg == REG_CTRL) && i_wdata[0];

        rd_rxdata = i_rd && (i_rreg == REG_RXDATA);
        rx_pop    = rd_rxdata && !rx_empty;
        rx_unf    = rd_rxdata && rx_empty;
        rx_push   = rx_valid && rx_ready;
        rx_flush  = i_wr && (i_wreg == REG_CTRL) && i_wdata[1];

        err_clr   = (i_wr && (i_wreg == REG_ERR)) ? i_wdata[1:0] : 2'b00;

        status    = {tx_full, tx_empty, rx_full, rx_empty, 12'd0,
                     8'(rx_level), 8'(tx_level)};
    end

    always_comb begin
        o_rdata = '0;
        case (i_rreg)
            REG_ID:     o_rdata = ID_VALUE;
            REG_STATUS: o_rdata = status;
            REG_RXDATA: o_rdata = rx_empty ? '0 : rx_mem[rx_rd_ptr];
            REG_ERR:    o_rdata = {30'd0, err};
            default:    o_rdata = '0;
        endcase
    end

    // FIFO storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= i_wdata;
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
            err       <= '0;
        end else begin
            // Flush wins over any push/pop on the same FIFO at this edge.
            if (tx_flush) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
                tx_level  <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + DEPTH_BITS'(1);
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + DEPTH_BITS'(1);
                tx_level <= tx_level + (DEPTH_BITS+1)'(tx_push) - (DEPTH_BITS+1)'(tx_pop);
            end

            if (rx_flush) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
                rx_level  <= '0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + DEPTH_BITS'(1);
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + DEPTH_BITS'(1);
                rx_level <= rx_level + (DEPTH_BITS+1)'(rx_push) - (DEPTH_BITS+1)'(rx_pop);
            end

            // Set events take priority over a same-edge write-1-to-clear.
            err <= (err & ~err_clr) | {rx_unf, tx_ovf};
        end
    end

endmodule
